pulse_meas_sched: RTL and testbench

- Schedules a single shared pulse-width measurement counter between two asynchronous pulse sources, PULSE_A and PULSE_B.
- Synchronises both inputs and arbitrates on rising edges. Measures the granted pulse's high time in SYS_CLK cycles and publishes the result on OUT_REG with a channel tag.
- Sits between the external pulse pins and the transmitter/receiver datapath. It replaces free-running per-channel counting with sequenced, one-at-a-time measurement.

---
 rtl/pulse_meas_pkg.sv | 30 +++
 rtl/pulse_sync_edge.sv | 35 +++
 rtl/pulse_meas_sched.sv | 196 +++++++++++++++++++
 tb/tb_pulse_meas_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meas_pkg.sv
// Shared types and helpers for the pulse-width measurement scheduler.
//   state_t : measurement FSM states (IDLE, MEAS)
//   chan_t  : pulse channel identifier (CH_A = 0, CH_B = 1)
//   DEF_CNT_W : default width of the measurement counter
//   sat_inc : saturating increment used by the measurement counter
package pulse_meas_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

    localparam int DEF_CNT_W = 5;

    // Increment that sticks at max; callers narrow the result to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max);
        if (value >= max) begin
            return max;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Multi-flop synchroniser plus rising-edge detector for one async pulse input.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (clears all flops)
//   din  : asynchronous pulse input
//   s    : synchronised level (last synchroniser stage)
//   rise : one-cycle strobe when s goes 0 -> 1
module pulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift the raw input through the synchroniser and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~prev;

endmodule

// File: rtl/pulse_meas_sched.sv
// Shares one pulse-width counter between two async pulse sources. Rising
// edges are arbitrated (round-robin on ties), the granted pulse's high time is
// counted in SYS_CLK cycles and published with its channel tag.
// Ports:
//   SYS_CLK   : system clock
//   A_RESET   : asynchronous active-high reset
//   PULSE_A/B : asynchronous pulse sources
//   ENABLE    : measurement enable; dropping it aborts a measurement
//   CLR_FLAGS : clears OVERFLOW / MISS_A / MISS_B (a same-cycle set wins)
//   OUT_REG   : last measured width, OUT_CH its channel (0=A, 1=B)
//   OUT_VALID : one-cycle strobe when OUT_REG/OUT_CH update
//   BUSY      : measurement in progress
//   OVERFLOW  : sticky, a measurement saturated
//   MISS_A/B  : sticky, a rising edge on that channel was not granted
module pulse_meas_sched
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             SYS_CLK,
    input  logic             A_RESET,
    input  logic             PULSE_A,
    input  logic             PULSE_B,
    input  logic             ENABLE,
    input  logic             CLR_FLAGS,
    output logic [CNT_W-1:0] OUT_REG,
    output logic             OUT_CH,
    output logic             OUT_VALID,
    output logic             BUSY,
    output logic             OVERFLOW,
    output logic             MISS_A,
    output logic             MISS_B
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s_a, rise_a, s_b, rise_b;

    state_t           state, state_n;
    chan_t            gnt, gnt_n;
    chan_t            rr, rr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] out_reg_n;
    logic             out_ch_n, out_valid_n;
    logic             overflow_n, miss_a_n, miss_b_n;
    logic             s_g, rise_o;
    chan_t            other;

    pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk (SYS_CLK),
        .rst (A_RESET),
        .din (PULSE_A),
        .s   (s_a),
        .rise(rise_a)
    );

    pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk (SYS_CLK),
        .rst (A_RESET),
        .din (PULSE_B),
        .s   (s_b),
        .rise(rise_b)
    );

    // Level of the granted channel, rise of the other one, and who the other one is.
    always_comb begin
        s_g    = 1'b0;
        rise_o = 1'b0;
        other  = CH_B;
        if (gnt == CH_A) begin
            s_g    = s_a;
            rise_o = rise_b;
            other  = CH_B;
        end else begin
            s_g    = s_b;
            rise_o = rise_a;
            other  = CH_A;
        end
    end

    // Next-state, counter, result and sticky-flag logic.
    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        rr_n        = rr;
        cnt_n       = cnt;
        out_reg_n   = OUT_REG;
        out_ch_n    = OUT_CH;
        out_valid_n = 1'b0;
        overflow_n  = OVERFLOW;
        miss_a_n    = MISS_A;
        miss_b_n    = MISS_B;

        // Clear first so any set condition below takes priority.
        if (CLR_FLAGS) begin
            overflow_n = 1'b0;
            miss_a_n   = 1'b0;
            miss_b_n   = 1'b0;
        end else begin
            overflow_n = OVERFLOW;
        end

        case (state)
            IDLE: begin
                if (ENABLE && rise_a && rise_b) begin
                    // Tie: pointer's channel wins, pointer flips, loser is flagged.
                    gnt_n   = rr;
                    rr_n    = (rr == CH_A) ? CH_B : CH_A;
                    cnt_n   = CNT_ONE;
                    state_n = MEAS;
                    if (rr == CH_A) begin
                        miss_b_n = 1'b1;
                    end else begin
                        miss_a_n = 1'b1;
                    end
                end else if (ENABLE && rise_a) begin
                    gnt_n   = CH_A;
                    cnt_n   = CNT_ONE;
                    state_n = MEAS;
                end else if (ENABLE && rise_b) begin
                    gnt_n   = CH_B;
                    cnt_n   = CNT_ONE;
                    state_n = MEAS;
                end else begin
                    state_n = IDLE;
                end
            end
            MEAS: begin
                if (!ENABLE) begin
                    state_n = IDLE;
                end else if (s_g) begin
                    cnt_n = CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
                    if (cnt == CNT_MAX) begin
                        overflow_n = 1'b1;
                    end else begin
                        overflow_n = overflow_n;
                    end
                    if (rise_o && (other == CH_A)) begin
                        miss_a_n = 1'b1;
                    end else if (rise_o) begin
                        miss_b_n = 1'b1;
                    end else begin
                        cnt_n = cnt_n;
                    end
                end else begin
                    // Granted pulse has fallen: publish, then hand over if the other side just rose.
                    out_reg_n   = cnt;
                    out_ch_n    = gnt;
                    out_valid_n = 1'b1;
                    if (rise_o) begin
                        gnt_n   = other;
                        cnt_n   = CNT_ONE;
                        state_n = MEAS;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge SYS_CLK or posedge A_RESET) begin
        if (A_RESET) begin
            state     <= IDLE;
            gnt       <= CH_A;
            rr        <= CH_A;
            cnt       <= '0;
            OUT_REG   <= '0;
            OUT_CH    <= 1'b0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            OVERFLOW  <= 1'b0;
            MISS_A    <= 1'b0;
            MISS_B    <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            rr        <= rr_n;
            cnt       <= cnt_n;
            OUT_REG   <= out_reg_n;
            OUT_CH    <= out_ch_n;
            OUT_VALID <= out_valid_n;
            BUSY      <= (state_n == MEAS);
            OVERFLOW  <= overflow_n;
            MISS_A    <= miss_a_n;
            MISS_B    <= miss_b_n;
        end
    end

endmodule

// File: tb/tb_pulse_meas_sched.sv
// Scoreboard bench for pulse_meas_sched: expected (channel, width) pairs are
// queued when pulses are driven and compared against OUT_VALID strobes.
module tb_pulse_meas_sched;

    localparam int CNT_W       = 5;
    localparam int SYNC_STAGES = 2;
    localparam int PER         = 100;

    logic             SYS_CLK = 1'b0;
    logic             A_RESET, PULSE_A, PULSE_B, ENABLE, CLR_FLAGS;
    logic [CNT_W-1:0] OUT_REG;
    logic             OUT_CH, OUT_VALID, BUSY, OVERFLOW, MISS_A, MISS_B;

    typedef struct {
        logic             ch;
        logic [CNT_W-1:0] val;
        time              t;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pulse_meas_sched #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .SYS_CLK  (SYS_CLK),
        .A_RESET  (A_RESET),
        .PULSE_A  (PULSE_A),
        .PULSE_B  (PULSE_B),
        .ENABLE   (ENABLE),
        .CLR_FLAGS(CLR_FLAGS),
        .OUT_REG  (OUT_REG),
        .OUT_CH   (OUT_CH),
        .OUT_VALID(OUT_VALID),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW),
        .MISS_A   (MISS_A),
        .MISS_B   (MISS_B)
    );

    always #(PER/2) SYS_CLK = ~SYS_CLK;

    // Capture every result strobe, sampled on the falling edge.
    always @(negedge SYS_CLK) begin : monitor
        res_t r;
        if (OUT_VALID === 1'b1) begin
            r.ch  = OUT_CH;
            r.val = OUT_REG;
            r.t   = $time;
            obs_q.push_back(r);
        end
    end

    task automatic push_exp(input logic ch, input int val);
        res_t e;
        e.ch  = ch;
        e.val = val[CNT_W-1:0];
        e.t   = 0;
        exp_q.push_back(e);
    endtask

    task automatic get_result(input int max_cyc, output bit got, output res_t r);
        got = 1'b0;
        for (int i = 0; i < max_cyc && obs_q.size() == 0; i++) @(negedge SYS_CLK);
        if (obs_q.size() > 0) begin
            r   = obs_q.pop_front();
            got = 1'b1;
        end else begin
            r.ch = 1'b0; r.val = '0; r.t = 0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge SYS_CLK); CLR_FLAGS = 1'b1;
        @(negedge SYS_CLK); CLR_FLAGS = 1'b0;
    endtask

    task automatic test_reset();
        A_RESET = 1'b1; PULSE_A = 1'b0; PULSE_B = 1'b0; ENABLE = 1'b1; CLR_FLAGS = 1'b0;
        #60;
        n_checks++; if (OUT_REG !== 5'd0) $display("FAIL reset_out_reg got %0d want 0", OUT_REG); else n_pass++;
        n_checks++; if (OUT_CH !== 1'b0) $display("FAIL reset_out_ch got %b want 0", OUT_CH); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid got %b want 0", OUT_VALID); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else n_pass++;
        n_checks++; if ({OVERFLOW, MISS_A, MISS_B} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {OVERFLOW, MISS_A, MISS_B}); else n_pass++;
        @(negedge SYS_CLK);
        A_RESET = 1'b0;
    endtask

    task automatic test_single_a();
        res_t r, e; bit got; time t_fall;
        @(negedge SYS_CLK);
        PULSE_A = 1'b1; push_exp(1'b0, 8);
        repeat (8) @(negedge SYS_CLK);
        PULSE_A = 1'b0; t_fall = $time;
        get_result(40, got, r); e = exp_q.pop_front();
        n_checks++; if (!got) $display("FAIL single_a_result got none want ch%0d=%0d", e.ch, e.val);
        else if (r.ch !== e.ch || r.val !== e.val) $display("FAIL single_a_result got ch%0d=%0d want ch%0d=%0d", r.ch, r.val, e.ch, e.val);
        else n_pass++;
        n_checks++; if (r.t !== t_fall + (SYNC_STAGES + 1) * PER)
            $display("FAIL single_a_latency got %0t want %0t", r.t, t_fall + (SYNC_STAGES + 1) * PER); else n_pass++;
        n_checks++; if ({OVERFLOW, MISS_A, MISS_B} !== 3'b000)
            $display("FAIL single_a_flags got %b want 000", {OVERFLOW, MISS_A, MISS_B}); else n_pass++;
    endtask

    task automatic test_busy_b();
        res_t r, e; bit got; int busy_cnt;
        busy_cnt = 0;
        while ($time < 1500) @(negedge SYS_CLK);
        PULSE_B = 1'b1; push_exp(1'b1, 12);
        for (int i = 0; i < 30; i++) begin
            @(negedge SYS_CLK);
            if (BUSY === 1'b1) busy_cnt++;
            if (i == 11) PULSE_B = 1'b0;
        end
        get_result(10, got, r); e = exp_q.pop_front();
        n_checks++; if (!got) $display("FAIL busy_b_result got none want ch%0d=%0d", e.ch, e.val);
        else if (r.ch !== e.ch || r.val !== e.val) $display("FAIL busy_b_result got ch%0d=%0d want ch%0d=%0d", r.ch, r.val, e.ch, e.val);
        else n_pass++;
        n_checks++; if (busy_cnt !== 12) $display("FAIL busy_b_cycles got %0d want 12", busy_cnt); else n_pass++;
    endtask

    task automatic test_simultaneous();
        res_t r, e; bit got;
        for (int k = 0; k < 2; k++) begin
            repeat (3) @(negedge SYS_CLK);
            PULSE_A = 1'b1; PULSE_B = 1'b1;
            if (k == 0) push_exp(1'b0, 3); else push_exp(1'b1, 6);
            repeat (3) @(negedge SYS_CLK);
            PULSE_A = 1'b0;
            repeat (3) @(negedge SYS_CLK);
            PULSE_B = 1'b0;
            get_result(40, got, r); e = exp_q.pop_front();
            n_checks++; if (!got) $display("FAIL simul%0d_result got none want ch%0d=%0d", k, e.ch, e.val);
            else if (r.ch !== e.ch || r.val !== e.val) $display("FAIL simul%0d_result got ch%0d=%0d want ch%0d=%0d", k, r.ch, r.val, e.ch, e.val);
            else n_pass++;
            n_checks++; if ({MISS_A, MISS_B} !== ((k == 0) ? 2'b01 : 2'b10))
                $display("FAIL simul%0d_miss got %b want %b", k, {MISS_A, MISS_B}, (k == 0) ? 2'b01 : 2'b10); else n_pass++;
            pulse_clr();
            n_checks++; if ({MISS_A, MISS_B} !== 2'b00) $display("FAIL simul%0d_clr got %b want 00", k, {MISS_A, MISS_B}); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        res_t r, e; bit got;
        repeat (3) @(negedge SYS_CLK);
        PULSE_A = 1'b1; push_exp(1'b0, 31);
        repeat (40) @(negedge SYS_CLK);
        PULSE_A = 1'b0;
        get_result(40, got, r); e = exp_q.pop_front();
        n_checks++; if (!got) $display("FAIL overflow_result got none want ch%0d=%0d", e.ch, e.val);
        else if (r.ch !== e.ch || r.val !== e.val) $display("FAIL overflow_result got ch%0d=%0d want ch%0d=%0d", r.ch, r.val, e.ch, e.val);
        else n_pass++;
        n_checks++; if (OVERFLOW !== 1'b1) $display("FAIL overflow_flag got %b want 1", OVERFLOW); else n_pass++;
        pulse_clr();
        n_checks++; if (OVERFLOW !== 1'b0) $display("FAIL overflow_clr got %b want 0", OVERFLOW); else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t r, e; bit got; int busy_cnt;
        busy_cnt = 0;
        repeat (3) @(negedge SYS_CLK);
        PULSE_A = 1'b1; push_exp(1'b0, 5); push_exp(1'b1, 4);
        for (int i = 0; i < 25; i++) begin
            @(negedge SYS_CLK);
            if (BUSY === 1'b1) busy_cnt++;
            if (i == 4) begin PULSE_A = 1'b0; PULSE_B = 1'b1; end
            if (i == 8) PULSE_B = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            get_result(10, got, r); e = exp_q.pop_front();
            n_checks++; if (!got) $display("FAIL b2b%0d_result got none want ch%0d=%0d", k, e.ch, e.val);
            else if (r.ch !== e.ch || r.val !== e.val) $display("FAIL b2b%0d_result got ch%0d=%0d want ch%0d=%0d", k, r.ch, r.val, e.ch, e.val);
            else n_pass++;
        end
        n_checks++; if (busy_cnt !== 9) $display("FAIL b2b_busy_cycles got %0d want 9", busy_cnt); else n_pass++;
        n_checks++; if ({MISS_A, MISS_B} !== 2'b00) $display("FAIL b2b_miss got %b want 00", {MISS_A, MISS_B}); else n_pass++;
    endtask

    task automatic test_enable_abort();
        repeat (3) @(negedge SYS_CLK);
        PULSE_A = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        ENABLE = 1'b0;
        @(negedge SYS_CLK);
        ENABLE = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        PULSE_A = 1'b0;
        repeat (10) @(negedge SYS_CLK);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL abort_no_valid got %0d strobes want 0", obs_q.size()); else n_pass++;
        n_checks++; if ({OUT_CH, OUT_REG} !== {1'b1, 5'd4})
            $display("FAIL abort_hold got ch%0d=%0d want ch1=4", OUT_CH, OUT_REG); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL abort_busy got %b want 0", BUSY); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        repeat (3) @(negedge SYS_CLK);
        PULSE_A = 1'b1;
        repeat (4) @(negedge SYS_CLK);
        n_checks++; if (BUSY !== 1'b1) $display("FAIL rstmid_pre_busy got %b want 1", BUSY); else n_pass++;
        #20 A_RESET = 1'b1;
        #1;
        n_checks++; if ({OUT_CH, OUT_REG} !== 6'd0) $display("FAIL rstmid_out got ch%0d=%0d want ch0=0", OUT_CH, OUT_REG); else n_pass++;
        n_checks++; if ({OUT_VALID, BUSY, OVERFLOW, MISS_A, MISS_B} !== 5'd0)
            $display("FAIL rstmid_status got %b want 00000", {OUT_VALID, BUSY, OVERFLOW, MISS_A, MISS_B}); else n_pass++;
        PULSE_A = 1'b0;
        @(negedge SYS_CLK);
        A_RESET = 1'b0;
        repeat (10) @(negedge SYS_CLK);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL rstmid_no_valid got %0d strobes want 0", obs_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_busy_b();
        test_simultaneous();
        test_overflow();
        test_back_to_back();
        test_enable_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
